// File: rtl/udp_tx_scheduler.sv
// Packet-level round-robin scheduler sharing one UDP/IP stack application port between NUM_CH sources.
// Define UDP_SCHED_PRIO0_EN to give channel 0 absolute priority over the round-robin channels.
module udp_tx_scheduler #(
  parameter int NUM_CH         = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int GAP_CYCLES     = 12,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CH*DATA_WIDTH-1:0] ch_data,
  input  logic [NUM_CH*16-1:0]         ch_len,
  input  logic [NUM_CH*16-1:0]         ch_dst_port,
  input  logic [NUM_CH-1:0]            ch_valid,
  output logic [NUM_CH-1:0]            ch_ready,
  output logic [DATA_WIDTH-1:0]        st_data,
  output logic [15:0]                  st_len,
  output logic [15:0]                  st_dst_port,
  output logic                         st_valid,
  input  logic                         st_ready,
  output logic [NUM_CH-1:0]            grant,
  output logic                         busy,
  output logic [31:0]                  pkt_count,
  output logic [15:0]                  drop_count
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int IDX_W = $clog2(NUM_CH);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]      GAP_LAST = (GAP_CYCLES == 0) ? 8'd0 : 8'(GAP_CYCLES - 1);
`ifdef UDP_SCHED_PRIO0_EN
  localparam bit SKIP_CH0 = 1'b1;
`else
  localparam bit SKIP_CH0 = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, XFER, GAP, DROP} state_t;

  state_t            state_reg, state_next;
  logic [NUM_CH-1:0] grant_reg, grant_next;
  logic [15:0]       len_reg, len_next;
  logic [15:0]       dst_reg, dst_next;
  logic [IDX_W-1:0]  last_reg, last_next;
  logic [16:0]       beat_cnt_reg, beat_cnt_next;
  logic [TO_W-1:0]   idle_cnt_reg, idle_cnt_next;
  logic [7:0]        gap_cnt_reg, gap_cnt_next;
  logic [31:0]       pkt_count_reg, pkt_count_next;
  logic [15:0]       drop_count_reg, drop_count_next;

  logic [DATA_WIDTH-1:0] data_sel [NUM_CH];
  logic [15:0]           len_ch   [NUM_CH];
  logic [15:0]           dst_ch   [NUM_CH];

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign data_sel[gi] = grant_reg[gi] ? ch_data[gi*DATA_WIDTH +: DATA_WIDTH] : '0;
      assign len_ch[gi]   = ch_len[gi*16 +: 16];
      assign dst_ch[gi]   = ch_dst_port[gi*16 +: 16];
    end
  endgenerate

  // Grant is cleared outside a packet, so OR-ing the masked slices yields zero there.
  always_comb begin
    st_data = '0;
    for (int i = 0; i < NUM_CH; i++) st_data = st_data | data_sel[i];
  end

  logic [IDX_W-1:0] win_idx, cand;
  logic             win_found, win_upd_last;
  logic [16:0]      win_words;

  always_comb begin
    win_idx      = '0;
    cand         = '0;
    win_found    = 1'b0;
    win_upd_last = 1'b1;
    for (int k = 1; k <= NUM_CH; k++) begin
      cand = IDX_W'((int'(last_reg) + k) % NUM_CH);
      if (!win_found && ch_valid[cand] && (!SKIP_CH0 || cand != '0)) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
`ifdef UDP_SCHED_PRIO0_EN
    if (ch_valid[0]) begin
      win_found    = 1'b1;
      win_idx      = '0;
      win_upd_last = 1'b0;
    end
`endif
  end

  // 17-bit ceiling division so a 65535-byte length cannot wrap.
  assign win_words = ({1'b0, len_ch[win_idx]} + 17'(BYTES - 1)) / 17'(BYTES);

  logic beat, pkt_inc, drop_inc, go_gap;

  assign st_valid = (state_reg == XFER) && |(ch_valid & grant_reg);
  assign beat     = st_valid && st_ready;

  always_comb begin
    ch_ready = '0;
    if (state_reg == XFER)      ch_ready = grant_reg & {NUM_CH{st_ready}};
    else if (state_reg == DROP) ch_ready = grant_reg;
  end

  always_comb begin
    state_next    = state_reg;
    grant_next    = grant_reg;
    len_next      = len_reg;
    dst_next      = dst_reg;
    last_next     = last_reg;
    beat_cnt_next = beat_cnt_reg;
    idle_cnt_next = idle_cnt_reg;
    gap_cnt_next  = gap_cnt_reg;
    pkt_inc       = 1'b0;
    drop_inc      = 1'b0;
    go_gap        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (win_found) begin
          grant_next    = {{(NUM_CH-1){1'b0}}, 1'b1} << win_idx;
          len_next      = len_ch[win_idx];
          dst_next      = dst_ch[win_idx];
          beat_cnt_next = win_words;
          idle_cnt_next = '0;
          if (win_upd_last) last_next = win_idx;
          state_next    = (len_ch[win_idx] == 16'd0) ? DROP : XFER;
        end
      end
      XFER: begin
        if (beat) begin
          idle_cnt_next = '0;
          if (beat_cnt_reg == 17'd1) begin
            pkt_inc = 1'b1;
            go_gap  = 1'b1;
          end else begin
            beat_cnt_next = beat_cnt_reg - 17'd1;
          end
        end else if (idle_cnt_reg == TO_LAST) begin
          drop_inc = 1'b1;
          go_gap   = 1'b1;
        end else begin
          idle_cnt_next = idle_cnt_reg + 1'b1;
        end
      end
      DROP: begin
        drop_inc = 1'b1;
        go_gap   = 1'b1;
      end
      GAP: begin
        if (gap_cnt_reg == GAP_LAST) state_next = IDLE;
        else                         gap_cnt_next = gap_cnt_reg + 8'd1;
      end
      default: state_next = IDLE;
    endcase
    if (go_gap) begin
      state_next   = GAP;
      grant_next   = '0;
      gap_cnt_next = '0;
    end
    pkt_count_next  = pkt_count_reg + (pkt_inc ? 32'd1 : 32'd0);
    drop_count_next = (drop_inc && drop_count_reg != 16'hFFFF) ? drop_count_reg + 16'd1
                                                               : drop_count_reg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      grant_reg      <= '0;
      len_reg        <= '0;
      dst_reg        <= '0;
      last_reg       <= IDX_W'(NUM_CH - 1);
      beat_cnt_reg   <= '0;
      idle_cnt_reg   <= '0;
      gap_cnt_reg    <= '0;
      pkt_count_reg  <= '0;
      drop_count_reg <= '0;
    end else begin
      state_reg      <= state_next;
      grant_reg      <= grant_next;
      len_reg        <= len_next;
      dst_reg        <= dst_next;
      last_reg       <= last_next;
      beat_cnt_reg   <= beat_cnt_next;
      idle_cnt_reg   <= idle_cnt_next;
      gap_cnt_reg    <= gap_cnt_next;
      pkt_count_reg  <= pkt_count_next;
      drop_count_reg <= drop_count_next;
    end
  end

  assign grant       = grant_reg;
  assign st_len      = len_reg;
  assign st_dst_port = dst_reg;
  assign busy        = (state_reg != IDLE);
  assign pkt_count   = pkt_count_reg;
  assign drop_count  = drop_count_reg;

endmodule

// File: tb/tb_udp_tx_scheduler.sv
// Directed bench for udp_tx_scheduler: per-channel beat queues drive the inputs, beats and grants are logged.
module tb_udp_tx_scheduler;
  localparam int NCH = 4;
  localparam int DW  = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NCH*DW-1:0] ch_data;
  logic [NCH*16-1:0] ch_len;
  logic [NCH*16-1:0] ch_dst_port;
  logic [NCH-1:0]    ch_valid;
  logic [NCH-1:0]    ch_ready;
  logic [DW-1:0]     st_data;
  logic [15:0]       st_len;
  logic [15:0]       st_dst_port;
  logic              st_valid;
  logic              st_ready;
  logic [NCH-1:0]    grant;
  logic              busy;
  logic [31:0]       pkt_count;
  logic [15:0]       drop_count;

  always #4 clk = ~clk;

  udp_tx_scheduler #(
    .NUM_CH(NCH), .DATA_WIDTH(DW), .GAP_CYCLES(12), .TIMEOUT_CYCLES(1024)
  ) dut (
    .clk(clk), .rst(rst), .ch_data(ch_data), .ch_len(ch_len), .ch_dst_port(ch_dst_port),
    .ch_valid(ch_valid), .ch_ready(ch_ready), .st_data(st_data), .st_len(st_len),
    .st_dst_port(st_dst_port), .st_valid(st_valid), .st_ready(st_ready), .grant(grant),
    .busy(busy), .pkt_count(pkt_count), .drop_count(drop_count)
  );

  int          n_vec = 0;
  int          n_bad = 0;
  logic [31:0] src_q [NCH][$];
  logic [15:0] len_cfg  [NCH];
  logic [15:0] port_cfg [NCH];
  logic [NCH-1:0] fire, prev_grant;
  logic        tog, leak;
  logic [31:0] obs_q [$];
  int          glog [$];
  int          gcyc [$];
  int          cyc, drop_cyc;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("  ok   %s = 0x%0h", tag, got);
    end
  endtask

  function automatic logic [31:0] obs_at(input int k);
    return (k < obs_q.size()) ? obs_q[k] : 32'hxxxxxxxx;
  endfunction

  function automatic int glog_at(input int k);
    return (k < glog.size()) ? glog[k] : -1;
  endfunction

  task automatic drive();
    for (int i = 0; i < NCH; i++) begin
      ch_valid[i]           = (src_q[i].size() > 0);
      ch_data[i*DW +: DW]   = (src_q[i].size() > 0) ? src_q[i][0] : '0;
      ch_len[i*16 +: 16]    = len_cfg[i];
      ch_dst_port[i*16 +: 16] = port_cfg[i];
    end
  endtask

  // One clock: consume accepted beats after the edge, then sample everything on the falling edge.
  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < NCH; i++) if (fire[i]) void'(src_q[i].pop_front());
    if (tog) st_ready = ~st_ready;
    drive();
    @(negedge clk);
    cyc++;
    fire = ch_valid & ch_ready;
    if (st_valid && st_ready) obs_q.push_back(st_data);
    if (grant != '0 && prev_grant == '0) begin
      for (int i = 0; i < NCH; i++) if (grant[i]) glog.push_back(i);
      gcyc.push_back(cyc);
    end
    prev_grant = grant;
    if ((ch_ready & ~grant) != '0) leak = 1'b1;
    if (grant == 4'b0100 && ch_ready == 4'b0100 && !st_valid) drop_cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tog = 1'b0;
    st_ready = 1'b1;
    for (int i = 0; i < NCH; i++) begin
      src_q[i].delete();
      len_cfg[i]  = '0;
      port_cfg[i] = '0;
    end
    drive();
    fire = '0;
    step();
    step();
    rst = 1'b0;
    obs_q.delete();
    glog.delete();
    gcyc.delete();
    leak = 1'b0;
    drop_cyc = 0;
    prev_grant = '0;
  endtask

  task automatic wait_idle(input string tag);
    for (int k = 0; k < 40 && busy; k++) step();
    chk(tag, busy, 1'b0);
  endtask

  initial begin
    int k, base;
    int exp_rr [5];
    int exp_pr [3];
    cyc = 0;
    fire = '0;
    prev_grant = '0;
    leak = 1'b0;
    drop_cyc = 0;
    st_ready = 1'b1;
    tog = 1'b0;

    // Reset state
    do_reset();
    chk("rst_grant", grant, 4'b0000);
    chk("rst_ch_ready", ch_ready, 4'b0000);
    chk("rst_st_valid", st_valid, 1'b0);
    chk("rst_st_data", st_data, 32'h0);
    chk("rst_st_len", st_len, 16'h0);
    chk("rst_st_dst_port", st_dst_port, 16'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_pkt_count", pkt_count, 32'h0);
    chk("rst_drop_count", drop_count, 16'h0);

    // Single packet on channel 1
    len_cfg[1]  = 16'd8;
    port_cfg[1] = 16'd12346;
    src_q[1].push_back(32'hDEADBEEF);
    src_q[1].push_back(32'hCAFEBABE);
    drive();
    for (k = 0; k < 20 && grant == '0; k++) step();
    chk("sp_grant", grant, 4'b0010);
    chk("sp_st_len", st_len, 16'd8);
    chk("sp_st_dst_port", st_dst_port, 16'd12346);
    chk("sp_busy", busy, 1'b1);
    for (k = 0; k < 20 && obs_q.size() < 2; k++) step();
    chk("sp_nbeats", obs_q.size(), 2);
    chk("sp_beat0", obs_at(0), 32'hDEADBEEF);
    chk("sp_beat1", obs_at(1), 32'hCAFEBABE);
    step();
    chk("sp_pkt_count", pkt_count, 32'd1);
    chk("sp_gap_grant", grant, 4'b0000);
    chk("sp_gap_busy", busy, 1'b1);
    chk("sp_gap_st_valid", st_valid, 1'b0);

    // Zero-length request on channel 2
    wait_idle("zl_idle_before");
    len_cfg[2] = 16'd0;
    port_cfg[2] = 16'd7;
    src_q[2].push_back(32'h0BAD0000);
    drive();
    for (k = 0; k < 20 && drop_count != 16'd1; k++) step();
    chk("zl_drop_count", drop_count, 16'd1);
    chk("zl_drop_cycles", drop_cyc, 1);
    chk("zl_consumed", src_q[2].size(), 0);
    chk("zl_pkt_count", pkt_count, 32'd1);

    // Channel 3 stalls after one of three beats; abort after 1024 idle cycles
    wait_idle("to_idle_before");
    len_cfg[3] = 16'd12;
    port_cfg[3] = 16'd9;
    src_q[3].push_back(32'h33330001);
    drive();
    base = obs_q.size();
    for (k = 0; k < 20 && obs_q.size() == base; k++) step();
    chk("to_first_beat", obs_at(base), 32'h33330001);
    k = 0;
    while (drop_count != 16'd2 && k < 1100) begin
      step();
      k++;
    end
    chk("to_abort_cycles", k, 1025);
    chk("to_drop_count", drop_count, 16'd2);
    chk("to_pkt_count", pkt_count, 32'd1);
    chk("to_gap_grant", grant, 4'b0000);

    // Reset in the middle of a 4-beat packet
    wait_idle("rm_idle_before");
    len_cfg[0] = 16'd16;
    for (int i = 0; i < 4; i++) src_q[0].push_back(32'hA0A0_0000 + i);
    drive();
    base = obs_q.size();
    for (k = 0; k < 20 && obs_q.size() < base + 2; k++) step();
    chk("rm_two_beats", obs_q.size() - base, 2);
    rst = 1'b1;
    step();
    chk("rm_grant", grant, 4'b0000);
    chk("rm_st_valid", st_valid, 1'b0);
    chk("rm_busy", busy, 1'b0);
    chk("rm_pkt_count", pkt_count, 32'd0);
    chk("rm_drop_count", drop_count, 16'd0);

    // Round-robin across all four channels
    do_reset();
    for (int i = 0; i < NCH; i++) begin
      len_cfg[i]  = 16'd4;
      port_cfg[i] = 16'd1000 + 16'(i);
      src_q[i].push_back(32'h1000_0000 + i);
    end
    src_q[0].push_back(32'h1000_0010);
    drive();
    for (k = 0; k < 200 && pkt_count != 32'd5; k++) step();
    chk("rr_pkt_count", pkt_count, 32'd5);
    exp_rr = '{0, 1, 2, 3, 0};
    for (int i = 0; i < 5; i++) chk($sformatf("rr_grant%0d", i), glog_at(i), exp_rr[i]);
    for (int i = 1; i < 5 && i < gcyc.size(); i++)
      chk($sformatf("rr_spacing%0d", i), gcyc[i] - gcyc[i-1], 14);

    // Backpressure: st_ready toggles during a 16-byte packet, channel 3 waits
    do_reset();
    len_cfg[0] = 16'd16;
    for (int i = 0; i < 4; i++) src_q[0].push_back(32'hB0B0_0000 + i);
    len_cfg[3] = 16'd4;
    src_q[3].push_back(32'hB3B3_0000);
    tog = 1'b1;
    drive();
    for (k = 0; k < 100 && pkt_count != 32'd1; k++) step();
    tog = 1'b0;
    st_ready = 1'b1;
    chk("bp_pkt_count", pkt_count, 32'd1);
    chk("bp_nbeats", obs_q.size(), 4);
    for (int i = 0; i < 4; i++) chk($sformatf("bp_beat%0d", i), obs_at(i), 32'hB0B0_0000 + i);
    chk("bp_first_grant", glog_at(0), 0);
    chk("bp_ready_leak", leak, 1'b0);

    // Channels 0 and 2 request continuously
    do_reset();
    len_cfg[0] = 16'd4;
    len_cfg[2] = 16'd4;
    for (int i = 0; i < 3; i++) begin
      src_q[0].push_back(32'hC000_0000 + i);
      src_q[2].push_back(32'hC200_0000 + i);
    end
    drive();
    for (k = 0; k < 200 && glog.size() < 3; k++) step();
`ifdef UDP_SCHED_PRIO0_EN
    exp_pr = '{0, 0, 0};
`else
    exp_pr = '{0, 2, 0};
`endif
    for (int i = 0; i < 3; i++) chk($sformatf("pr_grant%0d", i), glog_at(i), exp_pr[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/udp_tx_scheduler.md
# udp_tx_scheduler

Packet-level round-robin scheduler that shares the single application port of the UDP/IP transmit stack between `NUM_CH` sample-stream sources, such as ADC/DDC channels. It grants the port to one channel per packet and muxes that channel's data, length and destination port onto the stack. It also enforces an inter-packet gap and aborts stalled packets. It sits directly upstream of `udp_ip_stack`, and the stack's `app_*` ports connect one-to-one to the `st_*` ports here.

## Interface
- `NUM_CH`, default 4: number of requesting channels (2–8).
- `DATA_WIDTH`, default 32: data beat width in bits; the byte count per beat is `DATA_WIDTH/8`.
- `GAP_CYCLES`, default 12: idle cycles forced after every packet (0–255).
- `TIMEOUT_CYCLES`, default 1024: maximum cycles without a beat in XFER before the packet is aborted.

- `clk` input 1: single clock (125 MHz GMII domain).
- `rst` input 1: synchronous, active-high reset.
- `ch_data` input `NUM_CH*DATA_WIDTH`: per-channel data, channel i at bits `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `ch_len` input `NUM_CH*16`: per-channel payload length in bytes, sampled at grant.
- `ch_dst_port` input `NUM_CH*16`: per-channel UDP destination port, sampled at grant.
- `ch_valid` input `NUM_CH`: per-channel beat valid; a high bit also means the channel is requesting.
- `ch_ready` output `NUM_CH`: per-channel beat accept.
- `st_data` output `DATA_WIDTH`: data to the stack.
- `st_len` output 16: latched length of the granted packet.
- `st_dst_port` output 16: latched destination port of the granted packet.
- `st_valid` output 1: beat valid to the stack.
- `st_ready` input 1: beat accept from the stack.
- `grant` output `NUM_CH`: one-hot owner, all zeros when no channel owns the port.
- `busy` output 1: high in any state other than IDLE.
- `pkt_count` output 32: packets completed. Wraps at 2^32.
- `drop_count` output 16: zero-length requests dropped plus packets aborted. Saturates at 0xFFFF.

## Operation
- The FSM has four states: IDLE, XFER, GAP and DROP.
- **IDLE**
  - If `ch_valid` is nonzero, the winner is chosen round-robin, starting from the channel after the last winner (`last`, reset value `NUM_CH-1`).
  - The scheduler latches `grant`, `st_len` and `st_dst_port` from the winner and sets `last` to the winner.
  - Next state is XFER. If the winner's `ch_len` is 0, next state is DROP instead.
- **XFER**
  - `st_data` is `ch_data` of the granted channel, passed through combinationally.
  - `st_valid` is the granted channel's `ch_valid`.
  - `ch_ready` of the granted channel is `st_ready`; all other `ch_ready` bits are 0.
  - A beat is transferred when `st_valid && st_ready`.
  - The beat counter loads `ceil(st_len / (DATA_WIDTH/8))`, computed with 17-bit arithmetic so the maximum length of 65535 does not overflow, and decrements once per beat.
  - On the last beat: `pkt_count` increments and next state is GAP.
- **Timeout**
  - In XFER, an idle counter resets on every beat.
  - When the counter reaches `TIMEOUT_CYCLES`, the packet is aborted: `drop_count` increments and next state is GAP.
  - After an abort, any remaining beats from that channel are treated as a new request.
- **DROP**
  - Lasts one cycle.
  - The granted channel's `ch_ready` is 1 to consume the zero-length beat, `st_valid` is 0 and `drop_count` increments.
  - Next state is GAP.
- **GAP**
  - `grant` is 0, `st_valid` is 0 and every `ch_ready` bit is 0.
  - The scheduler waits `GAP_CYCLES` cycles, then returns to IDLE. With `GAP_CYCLES`=0, GAP lasts exactly one cycle.
- Outputs and counters outside the packet:
  - `st_data` is 0 when no channel is granted.
  - `st_len` and `st_dst_port` hold their last latched values.
  - `drop_count` saturates; `pkt_count` wraps.
- If a granted channel deasserts `ch_valid` mid-packet, the packet is stalled, not aborted, until the timeout.

## Timing
- Reset values:
  - state IDLE, `grant`=0, `ch_ready`=0, `st_valid`=0, `st_data`=0.
  - `st_len`=0, `st_dst_port`=0, `busy`=0, `pkt_count`=0, `drop_count`=0.
- `rst` asserted mid-packet returns the FSM to IDLE on the next edge. No count is incremented for the interrupted packet.
- Grant latency:
  - `ch_valid` high in IDLE at edge n gives `grant` and `busy` at n+1.
  - The first beat can transfer in the cycle after edge n+1.
- Minimum packet spacing is `words + GAP_CYCLES + 1` cycles.
- Simultaneous requests in IDLE are resolved by round-robin alone; no channel wins twice while another channel is requesting.

## Configuration
- `UDP_SCHED_PRIO0_EN` defined:
  - Channel 0 wins any IDLE arbitration in which it requests.
  - All other channels are arbitrated round-robin among themselves.
  - `last` is not updated when channel 0 wins.
- `UDP_SCHED_PRIO0_EN` undefined: pure round-robin over all `NUM_CH` channels.

## Test plan
- **Single packet.** Stimulus: channel 1 requests with `ch_len`=8, `ch_dst_port`=12346, beats 0xDEADBEEF and 0xCAFEBABE, `st_ready`=1. Required response:
  - `grant`=0010 and `st_len`=8.
  - Two beats appear on `st_data` in order.
  - `pkt_count`=1 and the FSM is in GAP the cycle after the last beat.
- **Round-robin.** Stimulus: all four channels hold `ch_valid` with `ch_len`=4. Required response: the grant sequence is 0,1,2,3,0, each packet is separated by ≥12 idle cycles, and `pkt_count`=5.
- **Backpressure.** Stimulus: `st_ready` toggles every other cycle during a 16-byte packet. Required response: exactly 4 beats, no data duplicated or lost, and non-granted `ch_ready` bits stay 0.
- **Zero length and timeout.**
  - Channel 2 with `ch_len`=0: one DROP cycle and `drop_count`=1.
  - Channel 3 with `ch_len`=12 that stops after 1 beat: abort after 1024 idle cycles and `drop_count`=2.
- **Reset mid-packet.** Stimulus: assert `rst` after beat 2 of 4. Required response: next edge shows `grant`=0, `st_valid`=0, and both counts 0.
- **Macro `UDP_SCHED_PRIO0_EN`.** Stimulus: channels 0 and 2 request continuously. Required response: channel 0 wins every arbitration. Without the macro, channels 0 and 2 alternate.
